// File: rtl/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher: cycle-exact scenario player driving set/wait/delay/check channels from a command stream
module tb_cmd_dispatcher #(
  parameter int SET_SIZE = 5,
  parameter int SET_WIDTH = 32,
  parameter int WAIT_SIZE = 5,
  parameter int CHECK_SIZE = 5,
  parameter int CHECK_WIDTH = 32,
  parameter int IDX_W = 3,
  parameter logic [SET_SIZE*SET_WIDTH-1:0] SET_INIT = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [2:0]                        cmd_op,
  input  logic [IDX_W-1:0]                  cmd_idx,
  input  logic [31:0]                       cmd_data,
  input  logic [WAIT_SIZE-1:0]              wait_signals,
  input  logic [CHECK_SIZE*CHECK_WIDTH-1:0] check_signals,
  output logic [SET_SIZE*SET_WIDTH-1:0]     set_signals,
  output logic                              busy,
  output logic                              done,
  output logic                              chk_pulse,
  output logic                              chk_pass,
  output logic [15:0]                       pass_cnt,
  output logic [15:0]                       fail_cnt
);
  typedef enum logic [2:0] {INIT, READY, WAIT_EVT, DELAY, DONE} state_t;
  state_t state;
  logic [WAIT_SIZE-1:0] wait_prev;
  logic [31:0] cnt, limit;
  logic [IDX_W-1:0] widx;
  logic wdir, accept, legal, chk_match, wcur, wprv, edge_hit, timeout, inc_pass, inc_fail;
  assign cmd_ready = state == READY;
  assign busy = state == WAIT_EVT || state == DELAY;
  // Channel selection, legality and the pass/fail events of the current cycle
  always_comb begin
    accept = cmd_valid & cmd_ready;
    chk_match = 1'b0;
    for (int k = 0; k < CHECK_SIZE; k++)
      if (int'(cmd_idx) == k) chk_match = check_signals[k*CHECK_WIDTH +: CHECK_WIDTH] == cmd_data[CHECK_WIDTH-1:0];
    wcur = 1'b0;
    wprv = 1'b0;
    for (int k = 0; k < WAIT_SIZE; k++)
      if (int'(widx) == k) begin
        wcur = wait_signals[k];
        wprv = wait_prev[k];
      end
    edge_hit = wdir ? (!wprv && wcur) : (wprv && !wcur);
    timeout = limit != 32'd0 && cnt == limit;
    legal = cmd_op == 3'd7 ? 1'b0 :
            cmd_op == 3'd1 ? int'(cmd_idx) < SET_SIZE :
            (cmd_op == 3'd2 || cmd_op == 3'd3) ? int'(cmd_idx) < WAIT_SIZE :
            cmd_op == 3'd5 ? int'(cmd_idx) < CHECK_SIZE : 1'b1;
    inc_pass = (accept && legal && cmd_op == 3'd5 && chk_match) || (state == WAIT_EVT && edge_hit);
    inc_fail = (accept && (!legal || (cmd_op == 3'd5 && !chk_match))) || (state == WAIT_EVT && !edge_hit && timeout);
  end
  // Sequencer FSM with registered outputs, saturating result counters and edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      set_signals <= SET_INIT;
      done <= 1'b0;
      chk_pulse <= 1'b0;
      chk_pass <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      wait_prev <= '0;
      cnt <= '0;
      limit <= '0;
      widx <= '0;
      wdir <= 1'b0;
    end else begin
      wait_prev <= wait_signals;
      chk_pulse <= 1'b0;
      if (inc_pass && pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
      if (inc_fail && fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
      case (state)
        INIT: state <= READY;
        READY:
          if (accept && legal)
            case (cmd_op)
              3'd1:
                for (int k = 0; k < SET_SIZE; k++)
                  if (int'(cmd_idx) == k) set_signals[k*SET_WIDTH +: SET_WIDTH] <= cmd_data[SET_WIDTH-1:0];
              3'd2, 3'd3: begin
                state <= WAIT_EVT;
                widx <= cmd_idx;
                wdir <= cmd_op == 3'd2;
                limit <= cmd_data;
                cnt <= 32'd1;
              end
              3'd4:
                if (cmd_data != 32'd0) begin
                  state <= DELAY;
                  cnt <= cmd_data - 32'd1;
                end
              3'd5: begin
                chk_pulse <= 1'b1;
                chk_pass <= chk_match;
              end
              3'd6: begin
                done <= 1'b1;
                state <= DONE;
              end
              default: ;
            endcase
        WAIT_EVT:
          if (edge_hit || timeout) begin
            state <= READY;
            chk_pulse <= 1'b1;
            chk_pass <= edge_hit;
          end else cnt <= cnt + 32'd1;
        DELAY:
          if (cnt == 32'd0) state <= READY;
          else cnt <= cnt - 32'd1;
        default: ;
      endcase
    end
  end
endmodule
